// File: rtl/alu_pkg.sv
// Shared opcode and MDU state encodings for the EX-stage ALU with multiply/divide.
package alu_pkg;

    // Opcodes driven by the pipeline decode stage (values 1..9 match the legacy ALU)
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_AND   = 5'd3;
    localparam logic [4:0] ALU_OR    = 5'd4;
    localparam logic [4:0] ALU_XOR   = 5'd5;
    localparam logic [4:0] ALU_LUI   = 5'd6;
    localparam logic [4:0] ALU_SLT   = 5'd7;
    localparam logic [4:0] ALU_SLL   = 5'd8;
    localparam logic [4:0] ALU_SRL   = 5'd9;
    localparam logic [4:0] ALU_SRA   = 5'd10;
    localparam logic [4:0] ALU_SLTU  = 5'd11;
    localparam logic [4:0] ALU_NOR   = 5'd12;
    localparam logic [4:0] ALU_MULT  = 5'd16;
    localparam logic [4:0] ALU_MULTU = 5'd17;
    localparam logic [4:0] ALU_DIV   = 5'd18;
    localparam logic [4:0] ALU_DIVU  = 5'd19;
    localparam logic [4:0] ALU_MFHI  = 5'd20;
    localparam logic [4:0] ALU_MFLO  = 5'd21;
    localparam logic [4:0] ALU_MTHI  = 5'd22;
    localparam logic [4:0] ALU_MTLO  = 5'd23;

    // Iterative multiply/divide sequencer states
    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_RUN  = 2'd1;
    localparam logic [1:0] MD_FIX  = 2'd2;

    // True for the opcodes that are handed to the iterative unit
    function automatic logic is_md_op(input logic [4:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) ||
               (op == ALU_DIV)  || (op == ALU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-subtract step
// per cycle on operand magnitudes, followed by a sign fix-up cycle.
// The first RUN cycle (counter 0) folds the operand signs into magnitudes,
// counters 1..WIDTH perform the WIDTH arithmetic steps.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fix,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    // acc_hi: partial product high half / remainder
    // acc_lo: multiplier shifting out, product low half / dividend shifting out, quotient
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    // opnd: multiplicand / divisor magnitude
    logic [WIDTH-1:0]   opnd_q, opnd_d;

    logic               is_signed;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod_neg;

    assign is_signed = (op == ALU_MULT) || (op == ALU_DIV);
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    // MSB of the difference acts as the borrow: remainder < divisor keeps it clean
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign prod_neg  = -{acc_hi_q, acc_lo_q};

    assign busy = (state_q != MD_IDLE);
    assign fix  = (state_q == MD_FIX);

    // Sequencer and datapath next-state: load, sign strip, WIDTH steps, fix-up
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d  = MD_RUN;
                    cnt_d    = '0;
                    is_div_d = (op == ALU_DIV) || (op == ALU_DIVU);
                    neg_a_d  = is_signed & a[WIDTH-1];
                    neg_b_d  = is_signed & b[WIDTH-1];
                    acc_hi_d = '0;
                    acc_lo_d = a;
                    opnd_d   = b;
                end
            end
            MD_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == '0) begin
                    // Most-negative value negates to itself, which is the correct unsigned magnitude
                    if (neg_a_q) acc_lo_d = -acc_lo_q;
                    if (neg_b_q) opnd_d = -opnd_q;
                end else if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_shift[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) state_d = MD_FIX;
            end
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush) state_d = MD_IDLE;
    end

    // Sign fix-up of the magnitude result presented during FIX
    always_comb begin
        hi_res = acc_hi_q;
        lo_res = acc_lo_q;
        if (is_div_q) begin
            // Zero divisor: magnitude loop leaves |a| as remainder, so the normal
            // remainder sign fix already restores data1 into hi
            if (opnd_q == '0)
                lo_res = '1;
            else if (neg_a_q ^ neg_b_q)
                lo_res = -acc_lo_q;
            if (neg_a_q) hi_res = -acc_hi_q;
        end else if (neg_a_q ^ neg_b_q) begin
            hi_res = prod_neg[2*WIDTH-1:WIDTH];
            lo_res = prod_neg[WIDTH-1:0];
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered result, valid/ready handshake and an
// iterative multiply/divide unit owning the architectural HI/LO registers.
// WIDTH must be even and at least 8.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int  WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         alu_ctrl,
    input  logic [WIDTH-1:0]   data1,
    input  logic [WIDTH-1:0]   data2,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               flush,
    output logic               out_valid,
    output logic [WIDTH-1:0]   alu_res,
    output logic               zero,
    output logic               ovf,
    output logic               md_busy,
    output logic               md_done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);
    logic               out_valid_q;
    logic [WIDTH-1:0]   alu_res_q;
    logic               zero_q;
    logic               ovf_q;
    logic               md_done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               accept;
    logic               is_md;
    logic               md_start;
    logic               md_busy_w;
    logic               md_fix;
    logic               md_write;
    logic [WIDTH-1:0]   md_hi;
    logic [WIDTH-1:0]   md_lo;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   res_d;
    logic               ovf_d;

    // Any MDU activity stalls every op so MFHI/MFLO never see stale HI/LO
    assign in_ready = ~md_busy_w & ~flush;
    assign accept   = in_valid & in_ready;
    assign is_md    = is_md_op(alu_ctrl);
    assign md_start = accept & is_md;
    assign md_write = md_fix & ~flush;
    assign sum      = data1 + data2;
    assign diff     = data1 - data2;

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .start  (md_start),
        .op     (alu_ctrl),
        .a      (data1),
        .b      (data2),
        .busy   (md_busy_w),
        .fix    (md_fix),
        .hi_res (md_hi),
        .lo_res (md_lo)
    );

    // Single-cycle result and signed-overflow selection for the simple ops
    always_comb begin
        res_d = '0;
        ovf_d = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                res_d = sum;
                ovf_d = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            ALU_SUB: begin
                res_d = diff;
                ovf_d = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
            end
            ALU_AND:  res_d = data1 & data2;
            ALU_OR:   res_d = data1 | data2;
            ALU_XOR:  res_d = data1 ^ data2;
            ALU_NOR:  res_d = ~(data1 | data2);
            ALU_LUI:  res_d = {data2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, (data1 < data2)};
            ALU_SLL:  res_d = data1 << shamt;
            ALU_SRL:  res_d = data1 >> shamt;
            ALU_SRA:  res_d = $signed(data1) >>> shamt;
            ALU_MFHI: res_d = hi_q;
            ALU_MFLO: res_d = lo_q;
            default:  res_d = '0;   // MTHI/MTLO and unknown opcodes report zero
        endcase
    end

    // Output, HI/LO and completion registers; flush suppresses result and HI/LO write
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_res_q   <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            md_done_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= accept & ~is_md;
            if (accept && !is_md) begin
                alu_res_q <= res_d;
                zero_q    <= (res_d == '0);
                ovf_q     <= ovf_d;
            end
            md_done_q <= md_write;
            if (md_write) begin
                hi_q <= md_hi;
                lo_q <= md_lo;
            end else if (accept && alu_ctrl == ALU_MTHI) begin
                hi_q <= data1;
            end else if (accept && alu_ctrl == ALU_MTLO) begin
                lo_q <= data1;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign alu_res   = alu_res_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign md_busy   = md_busy_w;
    assign md_done   = md_done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: the driver pushes hand-computed expectations,
// monitors pop and compare on out_valid / md_done.
module tb_alu_mdu;
    import alu_pkg::*;

    localparam int M_NONE = 0;
    localparam int M_RES  = 1;
    localparam int M_MD   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  alu_ctrl = 5'd0;
    logic [31:0] data1 = 32'd0;
    logic [31:0] data2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] alu_res;
    logic        zero;
    logic        ovf;
    logic        md_busy;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .data1     (data1),
        .data2     (data2),
        .shamt     (shamt),
        .flush     (flush),
        .out_valid (out_valid),
        .alu_res   (alu_res),
        .zero      (zero),
        .ovf       (ovf),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .hi        (hi),
        .lo        (lo)
    );

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] res;
        logic        z;
        logic        o;
    } exp_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] r;
        logic        o;
    } vec_t;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
    } mdv_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t res_q[$];
    logic [63:0] md_q[$];
    exp_t mon_e;
    logic [63:0] mon_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end else begin
            $display("check %s = %h", name, act);
        end
    endtask

    // Result monitor: one line per returned simple op
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result act res=%h exp none", alu_res);
            end else begin
                mon_e = res_q.pop_front();
                if ({alu_res, zero, ovf} !== {mon_e.res, mon_e.z, mon_e.o}) begin
                    errors++;
                    $display("FAIL result op=%0d act res=%h z=%b o=%b exp res=%h z=%b o=%b",
                             mon_e.op, alu_res, zero, ovf, mon_e.res, mon_e.z, mon_e.o);
                end else begin
                    $display("result op=%0d res=%h z=%b o=%b ok", mon_e.op, alu_res, zero, ovf);
                end
            end
        end
    end

    // HI/LO monitor: one line per completed mul/div
    always @(negedge clk) begin
        if (!rst && md_done) begin
            checks++;
            if (md_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_md_done act hi=%h lo=%h exp none", hi, lo);
            end else begin
                mon_m = md_q.pop_front();
                if ({hi, lo} !== mon_m) begin
                    errors++;
                    $display("FAIL hilo act hi=%h lo=%h exp hi=%h lo=%h",
                             hi, lo, mon_m[63:32], mon_m[31:0]);
                end else begin
                    $display("hilo hi=%h lo=%h ok", hi, lo);
                end
            end
        end
    end

    // Present one op, wait (bounded) for in_ready, push expectation at the accept edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input int mode, input logic [63:0] ev,
                         input logic eo);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        alu_ctrl = op;
        data1    = a;
        data2    = b;
        shamt    = sh;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout op=%0d act in_ready=0 exp 1", op);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (mode == M_RES) begin
            e.op  = op;
            e.res = ev[31:0];
            e.z   = (ev[31:0] == 32'd0);
            e.o   = eo;
            res_q.push_back(e);
        end else if (mode == M_MD) begin
            md_q.push_back(ev);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_md(input logic [4:0] op);
        int n;
        n = 0;
        while (!md_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!md_done) begin
            checks++;
            errors++;
            $display("FAIL md_timeout op=%0d act md_done=0 exp 1", op);
        end
    endtask

    vec_t vecs [0:21];
    mdv_t mdvs [0:7];

    initial begin
        int low_cnt;
        int done_edge;
        int c0;
        int dcnt;

        vecs = '{
            '{ALU_SUB,  32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b0},
            '{ALU_SRA,  32'h80000000, 32'h00000000, 5'd4,  32'hF8000000, 1'b0},
            '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0},
            '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0},
            '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000000, 1'b0},
            '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0},
            '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0},
            '{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0},
            '{ALU_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 1'b0},
            '{ALU_NOR,  32'h0F0F0F0F, 32'hF0F00000, 5'd0,  32'h0000F0F0, 1'b0},
            '{ALU_LUI,  32'h00000000, 32'hABCD1234, 5'd0,  32'h12340000, 1'b0},
            '{ALU_SLL,  32'h00000001, 32'h00000000, 5'd31, 32'h80000000, 1'b0},
            '{ALU_SRL,  32'h80000000, 32'h00000000, 5'd31, 32'h00000001, 1'b0},
            '{ALU_SRA,  32'h7FFFFFF0, 32'h00000000, 5'd4,  32'h07FFFFFF, 1'b0},
            '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b0},
            '{ALU_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b1},
            '{ALU_ADD,  32'h80000000, 32'h80000000, 5'd0,  32'h00000000, 1'b1},
            '{5'd13,    32'h00001234, 32'h00005678, 5'd0,  32'h00000000, 1'b0},
            '{ALU_MTHI, 32'h11112222, 32'h00000000, 5'd0,  32'h00000000, 1'b0},
            '{ALU_MTLO, 32'h33334444, 32'h00000000, 5'd0,  32'h00000000, 1'b0},
            '{ALU_MFHI, 32'h00000000, 32'h00000000, 5'd0,  32'h11112222, 1'b0},
            '{ALU_MFLO, 32'h00000000, 32'h00000000, 5'd0,  32'h33334444, 1'b0}
        };
        mdvs = '{
            '{ALU_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD},
            '{ALU_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF},
            '{ALU_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000},
            '{ALU_DIV,   32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF},
            '{ALU_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD},
            '{ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001},
            '{ALU_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000},
            '{ALU_DIVU,  32'h00000064, 32'h00000003, 64'h00000001_00000021}
        };

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_res", alu_res, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        chk("rst_hilo", {hi, lo}, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // Signed overflow on ADD, one-cycle out_valid pulse
        issue(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 5'd0, M_RES, 64'h80000000, 1'b1);
        @(negedge clk);
        chk("add_out_valid", out_valid, 1);
        @(negedge clk);
        chk("add_out_valid_drop", out_valid, 0);

        // Back-to-back simple ops: one negedge of lead-in plus one edge per op
        c0 = cyc;
        for (int i = 0; i < 22; i++)
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, M_RES, {32'd0, vecs[i].r}, vecs[i].o);
        chk("b2b_edges", cyc - c0, 23);
        @(negedge clk);
        chk("mthi_mtlo_regs", {hi, lo}, 64'h11112222_33334444);

        // MULT -3 x 7 with MFLO queued behind it
        issue(ALU_MULT, 32'hFFFFFFFD, 32'h00000007, 5'd0, M_MD, 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        low_cnt = 0;
        done_edge = 0;
        fork
            issue(ALU_MFLO, 32'd0, 32'd0, 5'd0, M_RES, 64'hFFFFFFEB, 1'b0);
            begin
                for (int k = 0; k < 100 && done_edge == 0; k++) begin
                    if (!in_ready) low_cnt++;
                    @(posedge clk);
                    #1;
                    if (md_done) done_edge = k + 1;
                end
            end
        join
        chk("mult_in_ready_low_cycles", low_cnt, 34);
        chk("mult_md_done_edge", done_edge, 34);
        @(negedge clk);
        chk("md_done_pulse_drop", md_done, 0);
        issue(ALU_MFHI, 32'd0, 32'd0, 5'd0, M_RES, 64'hFFFFFFFF, 1'b0);

        // Divide / multiply corner cases
        for (int i = 0; i < 8; i++) begin
            issue(mdvs[i].op, mdvs[i].a, mdvs[i].b, 5'd0, M_MD, mdvs[i].hilo, 1'b0);
            wait_md(mdvs[i].op);
        end
        @(negedge clk);
        chk("hilo_after_divu", {hi, lo}, 64'h00000001_00000021);

        // Flush during DIV 100/3 at cycle 10
        issue(ALU_DIV, 32'd100, 32'd3, 5'd0, M_NONE, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        alu_ctrl = ALU_ADD;
        data1    = 32'd1;
        data2    = 32'd1;
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_md_busy", md_busy, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_hilo_kept", {hi, lo}, 64'h00000001_00000021);
        c0 = cyc;
        issue(ALU_ADD, 32'd2, 32'd3, 5'd0, M_RES, 64'd5, 1'b0);
        chk("post_flush_accept_edges", cyc - c0, 1);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) dcnt++;
        end
        chk("flush_no_md_done", dcnt, 0);

        // Flush while idle blocks acceptance
        @(negedge clk);
        flush    = 1'b1;
        alu_ctrl = ALU_ADD;
        data1    = 32'd1;
        data2    = 32'd1;
        in_valid = 1'b1;
        #1;
        chk("idle_flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("idle_flush_no_result", out_valid, 0);

        // Reset in the middle of MULTU
        issue(ALU_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0, M_NONE, 64'd0, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_alu_res", alu_res, 0);
        chk("midrst_md_busy", md_busy, 0);
        chk("midrst_md_done", md_done, 0);
        chk("midrst_hilo", {hi, lo}, 0);
        chk("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        issue(ALU_ADD, 32'd2, 32'd3, 5'd0, M_RES, 64'd5, 1'b0);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_done) dcnt++;
        end
        chk("midrst_no_md_done", dcnt, 0);

        chk("res_queue_drained", res_q.size(), 0);
        chk("md_queue_drained", md_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
